// File: rtl/sys_clk_timer_host.sv
// Host-side sequencer driving an Avalon-MM interval timer slave: start, stop, IRQ service, snapshot.
// Optional snapshot path enabled by defining TIMER_HOST_SNAP_EN.
module sys_clk_timer_host #(
  parameter int unsigned CONT_MODE = 1,
  parameter int unsigned IRQ_EN    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cfg_period,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        snap_req,
  output logic        busy,
  output logic [31:0] tick_count,
  output logic [31:0] snap_value,
  output logic        snap_valid,
  output logic [2:0]  av_address,
  output logic        av_chipselect,
  output logic        av_write_n,
  output logic [15:0] av_writedata,
  input  logic [15:0] av_readdata,
  input  logic        av_irq
);

  localparam logic [1:0] CtrlLo = {CONT_MODE != 0, IRQ_EN != 0};

  typedef enum logic [3:0] {
    StIdle,
    StWrPl,
    StWrPh,
    StWrCtrl,
    StWrStop,
    StWrClr
`ifdef TIMER_HOST_SNAP_EN
    ,
    StWrSnap,
    StRdSl,
    StRdSh,
    StCapH
`endif
  } state_e;

  state_e      state_q, state_d;
  logic        start_pend_q, start_pend_d;
  logic        stop_pend_q, stop_pend_d;
  logic        snap_pend_q, snap_pend_d;
  logic [15:0] period_hi_q;
  logic [31:0] tick_q;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wd_q, wd_d;

  // Every command goes through its pending flag, so a command seen in IDLE is
  // dispatched on the following IDLE cycle; busy covers that pending cycle too.
  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q;
    stop_pend_d  = stop_pend_q;
    snap_pend_d  = snap_pend_q;

    if (cmd_start) start_pend_d = 1'b1;
    if (cmd_stop) begin
      stop_pend_d  = 1'b1;
      start_pend_d = 1'b0;
    end
`ifdef TIMER_HOST_SNAP_EN
    if (snap_req) snap_pend_d = 1'b1;
`else
    snap_pend_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        // A timeout landing during WR_CLR is cleared by the slave and lost; not compensated.
        if (av_irq) begin
          state_d = StWrClr;
        end else if (stop_pend_q) begin
          state_d     = StWrStop;
          stop_pend_d = 1'b0;
        end else if (start_pend_q) begin
          state_d      = StWrPl;
          start_pend_d = 1'b0;
        end else if (snap_pend_q) begin
`ifdef TIMER_HOST_SNAP_EN
          state_d = StWrSnap;
`endif
          snap_pend_d = 1'b0;
        end
      end
      StWrPl:   state_d = StWrPh;
      StWrPh:   state_d = StWrCtrl;
      StWrCtrl: state_d = StIdle;
      StWrStop: state_d = StIdle;
      StWrClr:  state_d = StIdle;
`ifdef TIMER_HOST_SNAP_EN
      StWrSnap: state_d = StRdSl;
      StRdSl:   state_d = StRdSh;
      StRdSh:   state_d = StCapH;
      StCapH:   state_d = StIdle;
`endif
      default:  state_d = StIdle;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with the state register.
  always_comb begin
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 3'd0;
    wd_d   = 16'h0000;
    unique case (state_d)
      StWrPl: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = cfg_period[15:0];
      end
      StWrPh: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = period_hi_q;
      end
      StWrCtrl: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = {12'h000, 2'b01, CtrlLo};
      end
      StWrStop: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = {12'h000, 2'b10, CtrlLo};
      end
      StWrClr: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0;
      end
`ifdef TIMER_HOST_SNAP_EN
      StWrSnap: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4;
      end
      StRdSl: begin
        cs_d = 1'b1; addr_d = 3'd4;
      end
      StRdSh: begin
        cs_d = 1'b1; addr_d = 3'd5;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      start_pend_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      snap_pend_q  <= 1'b0;
      period_hi_q  <= 16'h0000;
      tick_q       <= 32'h0;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      addr_q       <= 3'd0;
      wd_q         <= 16'h0000;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
      snap_pend_q  <= snap_pend_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
      if (state_d == StWrPl) period_hi_q <= cfg_period[31:16];
      if (state_d == StWrClr) tick_q <= tick_q + 32'd1;
    end
  end

`ifdef TIMER_HOST_SNAP_EN
  logic [15:0] snap_lo_q;
  logic [31:0] snap_q;
  logic        snap_valid_q;

  // Read data trails the address by one cycle, so each half is taken in the following state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_lo_q    <= 16'h0000;
      snap_q       <= 32'h0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= (state_q == StCapH);
      if (state_q == StRdSh) snap_lo_q <= av_readdata;
      if (state_q == StCapH) snap_q <= {av_readdata, snap_lo_q};
    end
  end

  assign snap_value = snap_q;
  assign snap_valid = snap_valid_q;
`else
  logic unused_snap;
  assign unused_snap = snap_req ^ (^av_readdata);
  assign snap_value  = 32'h0;
  assign snap_valid  = 1'b0;
`endif

  assign busy          = (state_q != StIdle) | start_pend_q | stop_pend_q | snap_pend_q;
  assign tick_count    = tick_q;
  assign av_chipselect = cs_q;
  assign av_write_n    = wn_q;
  assign av_address    = addr_q;
  assign av_writedata  = wd_q;

endmodule
